// File: rtl/sdram_mc_ctrl.sv
// Multi-channel SDRAM burst scheduler: round-robin arbitration of per-channel write
// and read bursts, with per-channel address wrap and optional ping-pong bank swapping.
module sdram_mc_ctrl #(
    parameter int CH_NUM = 2,
    parameter int AW     = 24,
    parameter int LW     = 10,
    parameter int NW     = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_end,
    input  logic [CH_NUM*NW-1:0] wr_fifo_num,
    input  logic [CH_NUM*NW-1:0] rd_fifo_num,
    input  logic [CH_NUM-1:0]    read_valid,
    input  logic [CH_NUM-1:0]    pingpang_en,
    input  logic [CH_NUM-1:0]    wr_rst,
    input  logic [CH_NUM-1:0]    rd_rst,
    input  logic [CH_NUM*AW-1:0] sdram_wr_b_addr,
    input  logic [CH_NUM*AW-1:0] sdram_wr_e_addr,
    input  logic [CH_NUM*AW-1:0] sdram_rd_b_addr,
    input  logic [CH_NUM*AW-1:0] sdram_rd_e_addr,
    input  logic [LW-1:0]        wr_burst_len,
    input  logic [LW-1:0]        rd_burst_len,
    input  logic                 sdram_wr_ack,
    input  logic                 sdram_rd_ack,
    output logic                 sdram_wr_req,
    output logic                 sdram_rd_req,
    output logic [AW-1:0]        sdram_wr_addr,
    output logic [AW-1:0]        sdram_rd_addr,
    output logic [CH_NUM-1:0]    wr_sel,
    output logic [CH_NUM-1:0]    rd_sel,
    output logic [CH_NUM-1:0]    wr_frame_done,
    output logic [CH_NUM-1:0]    rd_frame_done
);

    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int OW = AW - 2;
    localparam int MW = (NW > LW) ? NW : LW;

    typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST} state_t;

    state_t            state;
    logic [AW-1:0]     wr_addr [CH_NUM];
    logic [AW-1:0]     rd_addr [CH_NUM];
    logic [CH_NUM-1:0] bank_flag, rd_ready_q, rd_ready, wr_elig, rd_elig;
    logic [CW-1:0]     wr_ptr, rd_ptr, wr_ch, rd_ch, wr_grant, rd_grant;
    logic              wr_found, rd_found, wr_ack_dly, rd_ack_dly;
    logic              wr_rst_seen, rd_rst_seen, wr_done, rd_done;
    logic              end_bank_unused;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= CH_NUM) s = s - CH_NUM;
        return CW'(s);
    endfunction

    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] g);
        return (int'(g) == CH_NUM - 1) ? '0 : CW'(int'(g) + 1);
    endfunction

    // Only the offset field of the end address takes part in the wrap test.
    assign end_bank_unused = ^{sdram_wr_e_addr, sdram_rd_e_addr};
    assign rd_ready = ~pingpang_en | rd_ready_q;
    assign wr_done  = (state == WR_BURST) && wr_ack_dly && !sdram_wr_ack;
    assign rd_done  = (state == RD_BURST) && rd_ack_dly && !sdram_rd_ack;

    always_comb begin
        wr_elig  = '0;
        rd_elig  = '0;
        wr_found = 1'b0;
        rd_found = 1'b0;
        wr_grant = '0;
        rd_grant = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_elig[i] = MW'(wr_fifo_num[i*NW +: NW]) >= MW'(wr_burst_len);
            rd_elig[i] = read_valid[i] && rd_ready[i] &&
                         (MW'(rd_fifo_num[i*NW +: NW]) < MW'(rd_burst_len));
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (!wr_found && wr_elig[rr_idx(wr_ptr, k)]) begin
                wr_found = 1'b1;
                wr_grant = rr_idx(wr_ptr, k);
            end
            if (!rd_found && rd_elig[rr_idx(rd_ptr, k)]) begin
                rd_found = 1'b1;
                rd_grant = rr_idx(rd_ptr, k);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= '0;
            sdram_rd_addr <= '0;
            wr_sel        <= '0;
            rd_sel        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_ch         <= '0;
            rd_ch         <= '0;
            wr_rst_seen   <= 1'b0;
            rd_rst_seen   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_end && wr_found) begin
                        state         <= WR_WAIT;
                        sdram_wr_req  <= 1'b1;
                        sdram_wr_addr <= wr_addr[wr_grant];
                        wr_sel        <= CH_NUM'(1) << wr_grant;
                        wr_ch         <= wr_grant;
                        wr_ptr        <= next_ch(wr_grant);
                        wr_rst_seen   <= 1'b0;
                    end else if (init_end && rd_found) begin
                        state         <= RD_WAIT;
                        sdram_rd_req  <= 1'b1;
                        sdram_rd_addr <= rd_addr[rd_grant];
                        rd_sel        <= CH_NUM'(1) << rd_grant;
                        rd_ch         <= rd_grant;
                        rd_ptr        <= next_ch(rd_grant);
                        rd_rst_seen   <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (wr_rst[wr_ch]) wr_rst_seen <= 1'b1;
                    if (sdram_wr_ack) begin
                        sdram_wr_req <= 1'b0;
                        state        <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (wr_rst[wr_ch]) wr_rst_seen <= 1'b1;
                    if (wr_done) begin
                        wr_sel <= '0;
                        state  <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (rd_rst[rd_ch]) rd_rst_seen <= 1'b1;
                    if (sdram_rd_ack) begin
                        sdram_rd_req <= 1'b0;
                        state        <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (rd_rst[rd_ch]) rd_rst_seen <= 1'b1;
                    if (rd_done) begin
                        rd_sel <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A channel reset seen at any point of its burst suppresses the end-of-burst advance.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                wr_addr[i] <= '0;
                rd_addr[i] <= '0;
            end
            bank_flag     <= '0;
            rd_ready_q    <= '0;
            wr_frame_done <= '0;
            rd_frame_done <= '0;
            wr_ack_dly    <= 1'b0;
            rd_ack_dly    <= 1'b0;
        end else begin
            wr_ack_dly    <= sdram_wr_ack;
            rd_ack_dly    <= sdram_rd_ack;
            wr_frame_done <= '0;
            rd_frame_done <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                if (wr_rst[i]) begin
                    wr_addr[i]    <= sdram_wr_b_addr[i*AW +: AW];
                    bank_flag[i]  <= 1'b0;
                    rd_ready_q[i] <= 1'b0;
                end else if (wr_done && !wr_rst_seen && int'(wr_ch) == i) begin
                    if (wr_addr[i][OW-1:0] < sdram_wr_e_addr[i*AW +: OW] - OW'(wr_burst_len)) begin
                        wr_addr[i] <= wr_addr[i] + AW'(wr_burst_len);
                    end else begin
                        wr_frame_done[i] <= 1'b1;
                        if (pingpang_en[i]) begin
                            bank_flag[i]  <= ~bank_flag[i];
                            rd_ready_q[i] <= 1'b1;
                            wr_addr[i]    <= {1'b0, ~bank_flag[i], sdram_wr_b_addr[i*AW +: OW]};
                        end else begin
                            wr_addr[i] <= sdram_wr_b_addr[i*AW +: AW];
                        end
                    end
                end
                if (rd_rst[i]) begin
                    rd_addr[i] <= sdram_rd_b_addr[i*AW +: AW];
                end else if (rd_done && !rd_rst_seen && int'(rd_ch) == i) begin
                    if (rd_addr[i][OW-1:0] < sdram_rd_e_addr[i*AW +: OW] - OW'(rd_burst_len)) begin
                        rd_addr[i] <= rd_addr[i] + AW'(rd_burst_len);
                    end else begin
                        rd_frame_done[i] <= 1'b1;
                        if (pingpang_en[i]) begin
                            rd_addr[i] <= {1'b0, bank_flag[i], sdram_rd_b_addr[i*AW +: OW]};
                        end else begin
                            rd_addr[i] <= sdram_rd_b_addr[i*AW +: AW];
                        end
                    end
                end
            end
        end
    end

endmodule
